multicycle_ctrl_fsm: RTL and testbench
======================================

// Module: multicycle_ctrl_fsm
// PURPOSE
//  Main sequencer of the multicycle MIPS core: a Moore FSM through IF/ID/EX/MEM/WB.
//  Drives PC, IR, memory, register-file and ALU selects.
//  Consumes the branch evaluator's taken flag in EX to gate the PC write.
//  Counts retired instructions.
// PARAMETERS
//  CNT_W   32   width of the retired-instruction counter
// PORTS
//  clk          in   1      core clock; all state updates on posedge
//  rst_n        in   1      asynchronous, active-low reset
//  op           in   6      IR[31:26]; valid from ID onward
//  funct        in   6      IR[5:0]; R-type function field
//  branch_taken in   1      from branch evaluator; stable before posedge ending EX
//  mem_ready    in   1      memory done; used only when MC_MEM_WAIT_EN is defined
//  pc_write     out  1      PC load strobe
//  pc_src       out  2      0 = PC+4, 1 = branch target, 2 = jump target
//  ir_write     out  1      IR load strobe
//  mem_read     out  1      memory read enable
//  mem_write    out  1      memory write enable
//  reg_write    out  1      register-file write strobe
//  reg_dst      out  2      0 = rt, 1 = rd, 2 = r31
//  mem_to_reg   out  1      write-back source: 1 = memory, 0 = ALU
//  alu_src_b    out  2      0 = B, 1 = 4, 2 = sign-ext imm, 3 = zero-ext imm
//  alu_op       out  2      0 = add, 1 = sub, 2 = decode funct, 3 = decode op
//  illegal      out  1      1-cycle pulse on an undefined opcode
//  state        out  3      0 = IF, 1 = ID, 2 = EX, 3 = MEM, 4 = WB
//  retire_cnt   out  CNT_W  instructions completed
// BEHAVIOUR
//  - Reset (async, rst_n = 0): state = IF, all strobes 0, selects 0, retire_cnt = 0.
//    A reset mid-instruction abandons it with no partial writes. First fetch starts
//    in the first cycle after release.
//  - Outputs are a Moore decode of state and op_q (op captured at the ID posedge),
//    plus branch_taken in EX.
//  - IF: mem_read, ir_write, pc_write (pc_src = 0, alu_src_b = 1). Next state ID.
//  - ID: no strobes. Latch op_q. Next state EX.
//  - EX, R-type / ALU-immediate: next state WB.
//    alu_src_b = 0 / 2 / 3; zero-ext for ANDI, ORI, XORI.
//  - EX, load / store: alu_src_b = 2, alu_op = 0. Next state MEM.
//  - EX, BEQ / BNE / BLEZ / BGTZ / REGIMM: pc_src = 1, pc_write = branch_taken.
//    Retire. Next state IF.
//  - EX, J: pc_write = 1, pc_src = 2. Retire. Next state IF.
//  - EX, JAL: as J, plus reg_write = 1, reg_dst = 2. Retire. Next state IF.
//  - EX, undefined op: illegal = 1, no writes. Retire. Next state IF.
//  - MEM, load: mem_read. Next state WB.
//  - MEM, store: mem_write. Retire. Next state IF.
//  - WB: reg_write.
//    Load: reg_dst = 0, mem_to_reg = 1. R-type: reg_dst = 1. ALU-immediate: reg_dst = 0.
//    Retire. Next state IF.
//  - Latency in cycles: branch / jump 3, R-type / ALU-immediate 4, store 4, load 5.
//  - Retire: retire_cnt += 1 on the posedge leaving the final state.
//    Wraps from 2^CNT_W - 1 to 0.
//  - R-type with funct JR (001000): EX issues pc_write = 1, pc_src = 2 (jump mux
//    selects A). Retire. Next state IF.
// CONFIGURATION
//  MC_MEM_WAIT_EN defined:
//    - IF and MEM hold while mem_ready = 0; mem_read / mem_write stay asserted.
//    - ir_write, pc_write, the load/store transition and retire fire only in the
//      cycle mem_ready = 1.
//  MC_MEM_WAIT_EN undefined:
//    - mem_ready is ignored; memory is single-cycle.
// STRUCTURE
//  - Package mc_ctrl_pkg holds:
//    opcode constants (OP_*), funct JR, state encodings, pc_src / reg_dst / alu_src_b /
//    alu_op encodings.
//  - Sub-module mc_main_decoder (combinational): op, funct -> class one-hot
//    {rtype, alui, load, store, branch, j, jal, jr, illegal}.
//    The FSM and output decode stay in this module.
// TESTING
//  1. ADD (op 0, funct 100000) from reset -> states IF,ID,EX,WB,IF;
//     reg_write = 1, reg_dst = 1 in cycle 4; retire_cnt = 1.
//  2. LW (100011) -> 5 cycles; MEM mem_read = 1; WB mem_to_reg = 1, reg_dst = 0.
//     SW (101011) -> mem_write in cycle 4, no reg_write.
//  3. BEQ with branch_taken = 1 -> EX pc_write = 1, pc_src = 1.
//     With branch_taken = 0 -> pc_write = 0 in EX. Both return to IF after 3 cycles.
//  4. JAL (000011) -> EX pc_write = 1, pc_src = 2, reg_write = 1, reg_dst = 2.
//     Op 111111 -> illegal pulses once, no writes.
//  5. rst_n low during MEM of LW -> state = 0 and all strobes 0 immediately,
//     before the clock edge; retire_cnt = 0.
//  6. MC_MEM_WAIT_EN, mem_ready low 3 cycles in IF -> ir_write / pc_write only in the
//     4th cycle. CNT_W = 4 with 16 retires -> retire_cnt wraps to 0.

Source files
------------

// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared encodings for the multicycle MIPS control sequencer: states, opcodes, mux selects,
// and the instruction-class vector produced by the main decoder.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IF  = 3'd0,
        ST_ID  = 3'd1,
        ST_EX  = 3'd2,
        ST_MEM = 3'd3,
        ST_WB  = 3'd4
    } state_t;

    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_JAL    = 6'b000011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;
    localparam logic [5:0] OP_ADDI   = 6'b001000;
    localparam logic [5:0] OP_ADDIU  = 6'b001001;
    localparam logic [5:0] OP_SLTI   = 6'b001010;
    localparam logic [5:0] OP_SLTIU  = 6'b001011;
    localparam logic [5:0] OP_ANDI   = 6'b001100;
    localparam logic [5:0] OP_ORI    = 6'b001101;
    localparam logic [5:0] OP_XORI   = 6'b001110;
    localparam logic [5:0] OP_LUI    = 6'b001111;
    localparam logic [5:0] OP_LB     = 6'b100000;
    localparam logic [5:0] OP_LH     = 6'b100001;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_LBU    = 6'b100100;
    localparam logic [5:0] OP_LHU    = 6'b100101;
    localparam logic [5:0] OP_SB     = 6'b101000;
    localparam logic [5:0] OP_SH     = 6'b101001;
    localparam logic [5:0] OP_SW     = 6'b101011;

    localparam logic [5:0] FUNCT_JR  = 6'b001000;

    localparam logic [1:0] PC_SRC_PC4  = 2'd0;
    localparam logic [1:0] PC_SRC_BR   = 2'd1;
    localparam logic [1:0] PC_SRC_JMP  = 2'd2;

    localparam logic [1:0] REG_DST_RT  = 2'd0;
    localparam logic [1:0] REG_DST_RD  = 2'd1;
    localparam logic [1:0] REG_DST_R31 = 2'd2;

    localparam logic [1:0] ASB_B       = 2'd0;
    localparam logic [1:0] ASB_FOUR    = 2'd1;
    localparam logic [1:0] ASB_SEXT    = 2'd2;
    localparam logic [1:0] ASB_ZEXT    = 2'd3;

    localparam logic [1:0] ALU_ADD     = 2'd0;
    localparam logic [1:0] ALU_SUB     = 2'd1;
    localparam logic [1:0] ALU_FUNCT   = 2'd2;
    localparam logic [1:0] ALU_OP      = 2'd3;

    typedef struct packed {
        logic rtype;
        logic alui;
        logic load;
        logic store;
        logic branch;
        logic j;
        logic jal;
        logic jr;
        logic illegal;
    } op_class_t;

    // Logical immediates are zero-extended; arithmetic/compare immediates are sign-extended.
    function automatic logic imm_is_zext(input logic [5:0] op);
        return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Control bundle between the sequencer (master) and the datapath (slave).
interface multicycle_ctrl_fsm_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       op;
    logic [5:0]       funct;
    logic             branch_taken;
    logic             mem_ready;
    logic             pc_write;
    logic [1:0]       pc_src;
    logic             ir_write;
    logic             mem_read;
    logic             mem_write;
    logic             reg_write;
    logic [1:0]       reg_dst;
    logic             mem_to_reg;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic             illegal;
    logic [2:0]       state;
    logic [CNT_W-1:0] retire_cnt;

    modport master (
        input  op, funct, branch_taken, mem_ready,
        output pc_write, pc_src, ir_write, mem_read, mem_write, reg_write, reg_dst,
               mem_to_reg, alu_src_b, alu_op, illegal, state, retire_cnt
    );

    modport slave (
        output op, funct, branch_taken, mem_ready,
        input  pc_write, pc_src, ir_write, mem_read, mem_write, reg_write, reg_dst,
               mem_to_reg, alu_src_b, alu_op, illegal, state, retire_cnt
    );
endinterface

// File: rtl/multicycle_ctrl_fsm_main_decoder.sv
// Combinational opcode/funct classifier; exactly one class bit is set for any input.
import mc_ctrl_pkg::*;

module mc_main_decoder (
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    output op_class_t  cls_o
);
    always_comb begin
        cls_o = '0;
        case (op_i)
            OP_RTYPE: begin
                if (funct_i == FUNCT_JR) cls_o.jr    = 1'b1;
                else                     cls_o.rtype = 1'b1;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI:      cls_o.alui   = 1'b1;
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU:   cls_o.load   = 1'b1;
            OP_SB, OP_SH, OP_SW:                   cls_o.store  = 1'b1;
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ,
            OP_REGIMM:                             cls_o.branch = 1'b1;
            OP_J:                                  cls_o.j      = 1'b1;
            OP_JAL:                                cls_o.jal    = 1'b1;
            default:                               cls_o.illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle MIPS sequencer IF/ID/EX/MEM/WB with retire counter; 3-5 cycles per instruction.
// Stalls in IF/MEM on mem_ready only when MC_MEM_WAIT_EN is defined; otherwise memory is single-cycle.
import mc_ctrl_pkg::*;

module multicycle_ctrl_fsm #(
    parameter int CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    multicycle_ctrl_fsm_if.master bus
);
    state_t           state_q, state_d;
    logic [5:0]       op_q;
    logic [CNT_W-1:0] retire_q;
    logic             retire;
    logic             mem_ok;
    op_class_t        cls;

    mc_main_decoder u_dec (
        .op_i    (op_q),
        .funct_i (bus.funct),
        .cls_o   (cls)
    );

`ifdef MC_MEM_WAIT_EN
    assign mem_ok = bus.mem_ready;
`else
    assign mem_ok = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            ST_IF:  if (mem_ok) state_d = ST_ID;
            ST_ID:  state_d = ST_EX;
            ST_EX: begin
                if (cls.load || cls.store)      state_d = ST_MEM;
                else if (cls.rtype || cls.alui) state_d = ST_WB;
                else begin
                    state_d = ST_IF;
                    retire  = 1'b1;
                end
            end
            ST_MEM: begin
                if (mem_ok) begin
                    if (cls.load) state_d = ST_WB;
                    else begin
                        state_d = ST_IF;
                        retire  = 1'b1;
                    end
                end
            end
            ST_WB: begin
                state_d = ST_IF;
                retire  = 1'b1;
            end
            default: state_d = ST_IF;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IF;
            op_q     <= '0;
            retire_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_ID) op_q <= bus.op;
            if (retire) retire_q <= retire_q + 1'b1;
        end
    end

    // Moore decode of state/op_q; forced quiet while reset is held so nothing is written mid-reset.
    always_comb begin
        bus.pc_write   = 1'b0;
        bus.pc_src     = PC_SRC_PC4;
        bus.ir_write   = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.reg_write  = 1'b0;
        bus.reg_dst    = REG_DST_RT;
        bus.mem_to_reg = 1'b0;
        bus.alu_src_b  = ASB_B;
        bus.alu_op     = ALU_ADD;
        bus.illegal    = 1'b0;
        if (rst_n) begin
            case (state_q)
                ST_IF: begin
                    bus.mem_read  = 1'b1;
                    bus.alu_src_b = ASB_FOUR;
                    bus.ir_write  = mem_ok;
                    bus.pc_write  = mem_ok;
                end
                ST_EX: begin
                    if (cls.rtype) begin
                        bus.alu_op = ALU_FUNCT;
                    end else if (cls.alui) begin
                        bus.alu_op    = ALU_OP;
                        bus.alu_src_b = imm_is_zext(op_q) ? ASB_ZEXT : ASB_SEXT;
                    end else if (cls.load || cls.store) begin
                        bus.alu_src_b = ASB_SEXT;
                    end else if (cls.branch) begin
                        bus.alu_op   = ALU_SUB;
                        bus.pc_src   = PC_SRC_BR;
                        bus.pc_write = bus.branch_taken;
                    end else if (cls.j || cls.jr || cls.jal) begin
                        bus.pc_src    = PC_SRC_JMP;
                        bus.pc_write  = 1'b1;
                        bus.reg_write = cls.jal;
                        bus.reg_dst   = cls.jal ? REG_DST_R31 : REG_DST_RT;
                    end else begin
                        bus.illegal = 1'b1;
                    end
                end
                ST_MEM: begin
                    bus.mem_read  = cls.load;
                    bus.mem_write = cls.store;
                end
                ST_WB: begin
                    bus.reg_write  = 1'b1;
                    bus.mem_to_reg = cls.load;
                    bus.reg_dst    = cls.rtype ? REG_DST_RD : REG_DST_RT;
                end
                default: ;
            endcase
        end
    end

    assign bus.state      = rst_n ? state_q : ST_IF;
    assign bus.retire_cnt = retire_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed scoreboard bench for multicycle_ctrl_fsm; honours MC_MEM_WAIT_EN for the stall case.
`timescale 1ns/1ps
module tb_multicycle_ctrl_fsm;

    typedef struct packed {
        logic [2:0] st;
        logic       pcw;
        logic [1:0] pcs;
        logic       irw;
        logic       mr;
        logic       mw;
        logic       rw;
        logic [1:0] rd;
        logic       m2r;
        logic [1:0] asb;
        logic [1:0] aop;
        logic       ill;
        logic [3:0] cnt;
    } exp_t;

    logic clk;
    logic rst_n;
    logic [3:0] c;
    int   checks;
    int   errors;
    exp_t  sb[$];
    string tq[$];
    event  mon_ev;

    multicycle_ctrl_fsm_if #(.CNT_W(4)) bus ();
    multicycle_ctrl_fsm #(.CNT_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input int st, input int pcw, input int pcs, input int irw,
                                input int mr, input int mw, input int rw, input int rd,
                                input int m2r, input int asb, input int aop, input int ill,
                                input logic [3:0] cnt);
        return {st[2:0], pcw[0], pcs[1:0], irw[0], mr[0], mw[0], rw[0], rd[1:0],
                m2r[0], asb[1:0], aop[1:0], ill[0], cnt};
    endfunction

    //                                   st pcw pcs irw mr mw rw rd m2r asb aop ill
    function automatic exp_t e_if (input logic [3:0] k); return mk(0, 1, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0, k); endfunction
    function automatic exp_t e_ifw(input logic [3:0] k); return mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, k); endfunction
    function automatic exp_t e_id (input logic [3:0] k); return mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, k); endfunction
    function automatic exp_t e_rst();                    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0); endfunction

    always begin : monitor
        exp_t  e;
        exp_t  g;
        string t;
        @(negedge clk or mon_ev);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            t = tq.pop_front();
            g = {bus.state, bus.pc_write, bus.pc_src, bus.ir_write, bus.mem_read, bus.mem_write,
                 bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.alu_src_b, bus.alu_op,
                 bus.illegal, bus.retire_cnt};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL %s: got state=%0d vec=%h, required state=%0d vec=%h", t, g.st, g, e.st, e);
            end
        end
    end

    task automatic cyc(input string tag, input exp_t e, input logic [5:0] op_v,
                       input logic [5:0] fn_v, input logic bt, input logic mrdy);
        bus.op           = op_v;
        bus.funct        = fn_v;
        bus.branch_taken = bt;
        bus.mem_ready    = mrdy;
        sb.push_back(e);
        tq.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_decode(input string tag, input logic [5:0] op_v, input logic [5:0] fn_v);
        cyc({tag, "_IF"}, e_if(c), 6'h3f, 6'h3f, 1'b0, 1'b1);
        cyc({tag, "_ID"}, e_id(c), op_v, fn_v, 1'b0, 1'b1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0;
        errors = 0;
        c      = 4'd0;
        rst_n  = 1'b0;
        bus.op = 6'd0; bus.funct = 6'd0; bus.branch_taken = 1'b0; bus.mem_ready = 1'b1;
        @(posedge clk); #1;
        sb.push_back(e_rst()); tq.push_back("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // ADD: IF, ID, EX, WB
        fetch_decode("add", 6'b000000, 6'b100000);
        cyc("add_EX", mk(2,0,0,0,0,0,0,0,0,0,2,0,c), 6'b000000, 6'b100000, 1'b0, 1'b1);
        cyc("add_WB", mk(4,0,0,0,0,0,1,1,0,0,0,0,c), 6'b000000, 6'b100000, 1'b0, 1'b1);
        c = c + 4'd1;

        // LW then SW
        fetch_decode("lw", 6'b100011, 6'h00);
        cyc("lw_EX",  mk(2,0,0,0,0,0,0,0,0,2,0,0,c), 6'b100011, 6'h00, 1'b0, 1'b1);
        cyc("lw_MEM", mk(3,0,0,0,1,0,0,0,0,0,0,0,c), 6'b100011, 6'h00, 1'b0, 1'b1);
        cyc("lw_WB",  mk(4,0,0,0,0,0,1,0,1,0,0,0,c), 6'b100011, 6'h00, 1'b0, 1'b1);
        c = c + 4'd1;
        fetch_decode("sw", 6'b101011, 6'h00);
        cyc("sw_EX",  mk(2,0,0,0,0,0,0,0,0,2,0,0,c), 6'b101011, 6'h00, 1'b0, 1'b1);
        cyc("sw_MEM", mk(3,0,0,0,0,1,0,0,0,0,0,0,c), 6'b101011, 6'h00, 1'b0, 1'b1);
        c = c + 4'd1;

        // BEQ taken / not taken
        fetch_decode("beq_t", 6'b000100, 6'h00);
        cyc("beq_t_EX", mk(2,1,1,0,0,0,0,0,0,0,1,0,c), 6'b000100, 6'h00, 1'b1, 1'b1);
        c = c + 4'd1;
        fetch_decode("beq_n", 6'b000100, 6'h00);
        cyc("beq_n_EX", mk(2,0,1,0,0,0,0,0,0,0,1,0,c), 6'b000100, 6'h00, 1'b0, 1'b1);
        c = c + 4'd1;

        // JAL, illegal, ORI, JR
        fetch_decode("jal", 6'b000011, 6'h00);
        cyc("jal_EX", mk(2,1,2,0,0,0,1,2,0,0,0,0,c), 6'b000011, 6'h00, 1'b0, 1'b1);
        c = c + 4'd1;
        fetch_decode("ill", 6'b111111, 6'h00);
        cyc("ill_EX", mk(2,0,0,0,0,0,0,0,0,0,0,1,c), 6'b111111, 6'h00, 1'b1, 1'b1);
        c = c + 4'd1;
        fetch_decode("ori", 6'b001101, 6'h00);
        cyc("ori_EX", mk(2,0,0,0,0,0,0,0,0,3,3,0,c), 6'b001101, 6'h00, 1'b0, 1'b1);
        cyc("ori_WB", mk(4,0,0,0,0,0,1,0,0,0,0,0,c), 6'b001101, 6'h00, 1'b0, 1'b1);
        c = c + 4'd1;
        fetch_decode("jr", 6'b000000, 6'b001000);
        cyc("jr_EX", mk(2,1,2,0,0,0,0,0,0,0,0,0,c), 6'b000000, 6'b001000, 1'b0, 1'b1);
        c = c + 4'd1;

        // Reset asserted during MEM of a load: outputs drop before the next edge
        fetch_decode("lwr", 6'b100011, 6'h00);
        cyc("lwr_EX", mk(2,0,0,0,0,0,0,0,0,2,0,0,c), 6'b100011, 6'h00, 1'b0, 1'b1);
        sb.push_back(mk(3,0,0,0,1,0,0,0,0,0,0,0,c)); tq.push_back("lwr_MEM");
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        sb.push_back(e_rst()); tq.push_back("rst_async");
        ->mon_ev;
        @(posedge clk); #1;
        sb.push_back(e_rst()); tq.push_back("rst_hold");
        @(posedge clk); #1;
        rst_n = 1'b1;
        c = 4'd0;

        // Load with mem_ready low in IF and MEM
`ifdef MC_MEM_WAIT_EN
        repeat (3) cyc("wait_IF", e_ifw(c), 6'h3f, 6'h3f, 1'b0, 1'b0);
        cyc("wait_IF_go", e_if(c), 6'h3f, 6'h3f, 1'b0, 1'b1);
`else
        cyc("nowait_IF", e_if(c), 6'h3f, 6'h3f, 1'b0, 1'b0);
`endif
        cyc("wait_ID", e_id(c), 6'b100011, 6'h00, 1'b0, 1'b0);
        cyc("wait_EX", mk(2,0,0,0,0,0,0,0,0,2,0,0,c), 6'b100011, 6'h00, 1'b0, 1'b0);
`ifdef MC_MEM_WAIT_EN
        repeat (2) cyc("wait_MEM", mk(3,0,0,0,1,0,0,0,0,0,0,0,c), 6'b100011, 6'h00, 1'b0, 1'b0);
        cyc("wait_MEM_go", mk(3,0,0,0,1,0,0,0,0,0,0,0,c), 6'b100011, 6'h00, 1'b0, 1'b1);
`else
        cyc("nowait_MEM", mk(3,0,0,0,1,0,0,0,0,0,0,0,c), 6'b100011, 6'h00, 1'b0, 1'b0);
`endif
        cyc("wait_WB", mk(4,0,0,0,0,0,1,0,1,0,0,0,c), 6'b100011, 6'h00, 1'b0, 1'b1);
        c = c + 4'd1;

        // 15 jumps bring the 4-bit counter to 16 retires, wrapping to 0
        for (int i = 0; i < 15; i++) begin
            fetch_decode("j", 6'b000010, 6'h00);
            cyc("j_EX", mk(2,1,2,0,0,0,0,0,0,0,0,0,c), 6'b000010, 6'h00, 1'b0, 1'b1);
            c = c + 4'd1;
        end
        cyc("wrap_IF", e_if(c), 6'h3f, 6'h3f, 1'b0, 1'b1);

        @(negedge clk); #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending records, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
